// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one single-port data memory
//
// Optional feature macro: MEM_ARB_LOCK_EN (adds req_lock and a lock FSM so one
// requester can hold the memory across a read-modify-write sequence).
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req_valid/ready   per-requester handshake; a transfer is valid & ready
//   req_wr            per-requester 1 = write, 0 = read
//   req_addr/wdata    packed per-requester address / write data
//   req_lock          (MEM_ARB_LOCK_EN only) hold grant with this requester
//   rsp_valid         one-hot read response strobe, READ_LAT cycles after accept
//   rsp_rdata         read data, zero when no response is presented
//   mem_addr/data_in/wr/enable   drive of the memory pins in the grant cycle
//   mem_data_out      read data from the memory
module mem_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_data_in,
    output logic                      mem_wr,
    output logic                      mem_enable,
    input  logic [DATA_W-1:0]         mem_data_out
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] eligible;
    logic               grant;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    search_idx;
    logic               xfer;
    logic               ptr_advance;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_wr;
    logic               sel_lock;

    logic [READ_LAT-1:0] pipe_valid;
    logic [ID_W-1:0]     pipe_id [READ_LAT];

    // Round-robin search starting at rr_ptr; first eligible requester wins.
    always_comb begin
        grant      = 1'b0;
        winner     = '0;
        search_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            search_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant && eligible[search_idx]) begin
                grant  = 1'b1;
                winner = search_idx;
            end
        end
    end

    // Nothing is granted while reset is held, even though arbitration is combinational.
    assign xfer = grant && !rst;

    // Select the winner's request fields with constant slices.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        sel_lock  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_wr    = req_wr[i];
`ifdef MEM_ARB_LOCK_EN
                sel_lock  = req_lock[i];
`endif
            end
        end
    end

`ifdef MEM_ARB_LOCK_EN
    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

    lock_state_t     lock_state;
    lock_state_t     lock_state_nxt;
    logic [ID_W-1:0] lock_owner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_state <= UNLOCKED;
            lock_owner <= '0;
        end else begin
            lock_state <= lock_state_nxt;
            if (lock_state == UNLOCKED && xfer && sel_lock) begin
                lock_owner <= winner;
            end
        end
    end

    always_comb begin
        lock_state_nxt = lock_state;
        case (lock_state)
            UNLOCKED: if (xfer && sel_lock)  lock_state_nxt = LOCKED;
            LOCKED:   if (xfer && !sel_lock) lock_state_nxt = UNLOCKED;
            default:  lock_state_nxt = UNLOCKED;
        endcase
    end

    // While locked only the owner is eligible and the pointer is frozen until
    // the owner's releasing transfer, which advances past the owner.
    always_comb begin
        eligible    = req_valid;
        ptr_advance = xfer;
        if (lock_state == LOCKED) begin
            eligible    = req_valid & (NUM_REQ'(1) << lock_owner);
            ptr_advance = xfer && !sel_lock;
        end
    end
`else
    assign eligible    = req_valid;
    assign ptr_advance = xfer;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (ptr_advance) begin
            rr_ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
        end
    end

    // Memory drive and handshake for the grant cycle.
    always_comb begin
        req_ready   = '0;
        mem_addr    = '0;
        mem_data_in = '0;
        mem_wr      = 1'b0;
        mem_enable  = 1'b0;
        if (xfer) begin
            req_ready[winner] = 1'b1;
            mem_addr          = sel_addr;
            mem_data_in       = sel_wdata;
            mem_wr            = sel_wr;
            mem_enable        = 1'b1;
        end
    end

    // Read tracking: the tail stage lines up with mem_data_out of that read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_id[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= xfer && !sel_wr;
            pipe_id[0]    <= winner;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_id[i]    <= pipe_id[i-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (pipe_valid[READ_LAT-1]) begin
            rsp_valid[pipe_id[READ_LAT-1]] = 1'b1;
            rsp_rdata                      = mem_data_out;
        end
    end

endmodule
